// File: rtl/blind_ctrl_multistop.sv
// Multi-stop blind motor controller: prescaled tick, reversal dead time, motion timeout fault, position report.
// Optional macro AUTO_DEBOUNCE_EN: auto-mode target only follows light held equal on two consecutive ticks.
module blind_ctrl_multistop #(
    parameter int NUM_POS        = 4,
    parameter int PRESCALE_W     = 25,
    parameter int TIMEOUT_TICKS  = 20,
    parameter int DEADTIME_TICKS = 2,
    localparam int PW = (NUM_POS > 1) ? $clog2(NUM_POS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    input  logic                cmd_auto,
    input  logic [PW-1:0]       cmd_target,
    input  logic [NUM_POS-1:0]  pos_sw,
    input  logic [1:0]          light,
    output logic                motor_up,
    output logic                motor_down,
    output logic                tick,
    output logic                at_target,
    output logic                fault,
    output logic [PW-1:0]       cur_pos
);

    localparam int TMAX = (TIMEOUT_TICKS > DEADTIME_TICKS) ? TIMEOUT_TICKS : DEADTIME_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [PW-1:0] TOP_POS = PW'(NUM_POS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_UP    = 3'd1,
        S_DOWN  = 3'd2,
        S_DEAD  = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    // Returns {exactly_one_bit_set, index_of_set_bit}.
    function automatic logic [PW:0] decode_pos(input logic [NUM_POS-1:0] sw);
        logic [PW-1:0] idx;
        int            cnt;
        idx = '0;
        cnt = 32'sd0;
        for (int i = 0; i < NUM_POS; i++) begin
            idx = sw[i] ? PW'(i) : idx;
            cnt = cnt + (sw[i] ? 32'sd1 : 32'sd0);
        end
        return {(cnt == 32'sd1), idx};
    endfunction

    function automatic logic [PW-1:0] light_to_pos(input logic [1:0] lvl);
        int v;
        v = (int'(lvl) * (NUM_POS - 1)) / 32'sd3;
        return PW'(v);
    endfunction

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  tick_q, tick_d;
    logic [PW-1:0]         cur_pos_q, cur_pos_d;
    logic [PW-1:0]         target_q, target_d;
    logic                  mode_q, mode_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic                  motor_up_q, motor_up_d;
    logic                  motor_down_q, motor_down_d;
    logic                  at_target_q, at_target_d;
    logic                  fault_q, fault_d;
    logic [PW:0]           pos_dec_s;
    logic [PW-1:0]         light_tgt_s;
    logic                  pos_chg_s;
`ifdef AUTO_DEBOUNCE_EN
    logic [1:0]            light_prev_q, light_prev_d;
    logic                  light_ok_q, light_ok_d;
`endif

    // Prescaler, position tracking, mode and target selection.
    always_comb begin
        presc_d     = presc_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        tick_d      = (presc_d == {PRESCALE_W{1'b1}});
        pos_dec_s   = decode_pos(pos_sw);
        light_tgt_s = light_to_pos(light);
        mode_d      = mode_q;
        target_d    = target_q;
        if (pos_dec_s[PW]) begin
            cur_pos_d = pos_dec_s[PW-1:0];
        end else begin
            cur_pos_d = cur_pos_q;
        end
`ifdef AUTO_DEBOUNCE_EN
        light_prev_d = light_prev_q;
        light_ok_d   = light_ok_q;
        if (tick_q) begin
            light_prev_d = light;
            light_ok_d   = 1'b1;
        end else begin
            light_prev_d = light_prev_q;
        end
`endif
        // A command in the same cycle as a tick takes precedence over the light update.
        if (cmd_valid) begin
            mode_d = cmd_auto;
            if (!cmd_auto) begin
                target_d = (cmd_target > TOP_POS) ? TOP_POS : cmd_target;
            end else begin
                target_d = target_q;
            end
`ifdef AUTO_DEBOUNCE_EN
            if (cmd_auto && !mode_q) begin
                light_ok_d = 1'b0;
            end else begin
                light_ok_d = light_ok_d;
            end
`endif
        end else if (mode_q && tick_q) begin
`ifdef AUTO_DEBOUNCE_EN
            if (light_ok_q && (light == light_prev_q)) begin
                target_d = light_tgt_s;
            end else begin
                target_d = target_q;
            end
`else
            target_d = light_tgt_s;
`endif
        end else begin
            target_d = target_q;
        end
    end

    // Motion FSM next state, shared tick timer, and registered output values.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        pos_chg_s = (cur_pos_d != cur_pos_q);
        case (state_q)
            S_IDLE: begin
                if ((target_d > cur_pos_d) && !pos_sw[NUM_POS-1]) begin
                    state_d = S_UP;
                end else if ((target_d < cur_pos_d) && !pos_sw[0]) begin
                    state_d = S_DOWN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            // cur_pos >= target also covers a target that moved below us (reversal).
            S_UP: begin
                if (pos_sw[NUM_POS-1] || (cur_pos_d >= target_d)) begin
                    state_d = S_DEAD;
                end else if (tick_q && !pos_chg_s && (tmr_q == TW'(TIMEOUT_TICKS - 1))) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_UP;
                end
            end
            S_DOWN: begin
                if (pos_sw[0] || (cur_pos_d <= target_d)) begin
                    state_d = S_DEAD;
                end else if (tick_q && !pos_chg_s && (tmr_q == TW'(TIMEOUT_TICKS - 1))) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_DOWN;
                end
            end
            S_DEAD: begin
                if (tick_q && (tmr_q == TW'(DEADTIME_TICKS - 1))) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DEAD;
                end
            end
            S_FAULT: begin
                if (cmd_valid) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FAULT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (((state_q == S_UP) || (state_q == S_DOWN)) && pos_chg_s) begin
            tmr_d = '0;
        end else if (tick_q && ((state_q == S_UP) || (state_q == S_DOWN) || (state_q == S_DEAD))) begin
            tmr_d = tmr_q + TW'(1);
        end else begin
            tmr_d = tmr_q;
        end

        motor_up_d   = (state_d == S_UP);
        motor_down_d = (state_d == S_DOWN);
        fault_d      = (state_d == S_FAULT);
        at_target_d  = (state_d == S_IDLE) && (cur_pos_d == target_d);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            tick_q       <= 1'b0;
            cur_pos_q    <= '0;
            target_q     <= '0;
            mode_q       <= 1'b0;
            tmr_q        <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            at_target_q  <= 1'b0;
            fault_q      <= 1'b0;
`ifdef AUTO_DEBOUNCE_EN
            light_prev_q <= 2'd0;
            light_ok_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            tick_q       <= tick_d;
            cur_pos_q    <= cur_pos_d;
            target_q     <= target_d;
            mode_q       <= mode_d;
            tmr_q        <= tmr_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            at_target_q  <= at_target_d;
            fault_q      <= fault_d;
`ifdef AUTO_DEBOUNCE_EN
            light_prev_q <= light_prev_d;
            light_ok_q   <= light_ok_d;
`endif
        end
    end

    assign motor_up   = motor_up_q;
    assign motor_down = motor_down_q;
    assign tick       = tick_q;
    assign at_target  = at_target_q;
    assign fault      = fault_q;
    assign cur_pos    = cur_pos_q;

endmodule

// File: tb/tb_blind_ctrl_multistop.sv
// Self-checking bench for blind_ctrl_multistop: vector table + scoreboard queue + multi-cycle sequences.
module tb_blind_ctrl_multistop;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_auto;
    logic [1:0] cmd_target;
    logic [3:0] pos_sw;
    logic [1:0] light;
    logic       motor_up, motor_down, tick, at_target, fault;
    logic [1:0] cur_pos;

    logic       cmd_valid3, cmd_auto3;
    logic [1:0] cmd_target3;
    logic [2:0] pos_sw3;
    logic [1:0] light3;
    logic       motor_up3, motor_down3, tick3, at_target3, fault3;
    logic [1:0] cur_pos3;

    int checks = 0;
    int errors = 0;

`ifdef AUTO_DEBOUNCE_EN
    localparam int LIGHT_REACT_TICKS = 2;
`else
    localparam int LIGHT_REACT_TICKS = 1;
`endif

    blind_ctrl_multistop #(.NUM_POS(4), .PRESCALE_W(4), .TIMEOUT_TICKS(8), .DEADTIME_TICKS(2)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_auto(cmd_auto), .cmd_target(cmd_target),
        .pos_sw(pos_sw), .light(light), .motor_up(motor_up), .motor_down(motor_down), .tick(tick),
        .at_target(at_target), .fault(fault), .cur_pos(cur_pos)
    );

    blind_ctrl_multistop #(.NUM_POS(3), .PRESCALE_W(4), .TIMEOUT_TICKS(8), .DEADTIME_TICKS(2)) u_dut3 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_auto(cmd_auto3), .cmd_target(cmd_target3),
        .pos_sw(pos_sw3), .light(light3), .motor_up(motor_up3), .motor_down(motor_down3), .tick(tick3),
        .at_target(at_target3), .fault(fault3), .cur_pos(cur_pos3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pos_sw;
        logic       cv;
        logic       ca;
        logic [1:0] ct;
        logic [1:0] light;
        logic [1:0] cur;
        logic       up;
        logic       dn;
        logic       at;
        logic       flt;
    } vec_t;

    typedef struct {
        int         id;
        logic [1:0] cur;
        logic       up;
        logic       dn;
        logic       at;
        logic       flt;
    } exp_t;

    vec_t tbl[7];
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard consumer: one expected record per driven cycle, checked just after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk($sformatf("sb%0d_cur_pos", mon_e.id), 16'(cur_pos), 16'(mon_e.cur));
            chk($sformatf("sb%0d_motor_up", mon_e.id), 16'(motor_up), 16'(mon_e.up));
            chk($sformatf("sb%0d_motor_down", mon_e.id), 16'(motor_down), 16'(mon_e.dn));
            chk($sformatf("sb%0d_at_target", mon_e.id), 16'(at_target), 16'(mon_e.at));
            chk($sformatf("sb%0d_fault", mon_e.id), 16'(fault), 16'(mon_e.flt));
        end
        chk("motors_exclusive", 16'(motor_up & motor_down), 16'd0);
        chk("motors3_exclusive", 16'(motor_up3 & motor_down3), 16'd0);
    end

    task automatic apply(input logic [3:0] ps, input logic cv, input logic ca, input logic [1:0] ct,
                         input logic [1:0] lt, input logic [1:0] cur, input logic up, input logic dn,
                         input logic at, input logic flt, input int id);
        exp_t e;
        pos_sw = ps; cmd_valid = cv; cmd_auto = ca; cmd_target = ct; light = lt;
        e.id = id; e.cur = cur; e.up = up; e.dn = dn; e.at = at; e.flt = flt;
        exp_q.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    function automatic logic sel(input int w);
        case (w)
            0: return motor_up;
            1: return motor_down;
            2: return at_target;
            3: return fault;
            4: return motor_down3;
            5: return at_target3;
            default: return 1'b0;
        endcase
    endfunction

    // Waits (bounded) for an output to reach val, counting tick pulses seen meanwhile.
    task automatic wait_out(input string name, input int which, input logic val, input int budget,
                            input int exp_ticks);
        int ticks = 0;
        logic hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sel(which) == val) begin
                hit = 1'b1;
                break;
            end
            if ((which >= 4) ? tick3 : tick) ticks++;
            @(negedge clk);
        end
        chk({name, "_reached"}, 16'(hit), 16'd1);
        if (exp_ticks >= 0) chk({name, "_ticks"}, 16'(ticks), 16'(exp_ticks));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //             pos_sw   cv    ca    ct    light cur   up    dn    at    flt
        tbl[0] = '{4'b0001, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{4'b0001, 1'b1, 1'b0, 2'd2, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{4'b0010, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{4'b0110, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{4'b0100, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{4'b0100, 1'b1, 1'b0, 2'd2, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_auto = 1'b0; cmd_target = 2'd0; pos_sw = 4'b0000; light = 2'd0;
        cmd_valid3 = 1'b0; cmd_auto3 = 1'b0; cmd_target3 = 2'd0; pos_sw3 = 3'b000; light3 = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_motor_up", 16'(motor_up), 16'd0);
        chk("rst_motor_down", 16'(motor_down), 16'd0);
        chk("rst_tick", 16'(tick), 16'd0);
        chk("rst_fault", 16'(fault), 16'd0);
        chk("rst_cur_pos", 16'(cur_pos), 16'd0);
        reset = 1'b0;

        // Manual move 0 -> 2 through intermediate switch patterns.
        for (int i = 0; i < 7; i++) begin
            apply(tbl[i].pos_sw, tbl[i].cv, tbl[i].ca, tbl[i].ct, tbl[i].light,
                  tbl[i].cur, tbl[i].up, tbl[i].dn, tbl[i].at, tbl[i].flt, i);
        end
        wait_out("s1_settle", 2, 1'b1, 60, 2);
        chk("s1_cur_pos", 16'(cur_pos), 16'd2);

        // Timeout: commanded up but switch never changes.
        apply(4'b0100, 1'b1, 1'b0, 2'd3, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 10);
        wait_out("s2_fault", 3, 1'b1, 200, 8);
        chk("s2_fault_motor_up", 16'(motor_up), 16'd0);
        chk("s2_fault_motor_down", 16'(motor_down), 16'd0);
        apply(4'b0100, 1'b1, 1'b0, 2'd2, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 11);

        // Reversal while moving up.
        apply(4'b0000, 1'b1, 1'b0, 2'd3, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 20);
        apply(4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 21);
        apply(4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 22);
        wait_out("s3_down", 1, 1'b1, 80, 2);

        // Auto mode: bottom reached, then light 3 raises, light 0 lowers.
        apply(4'b0001, 1'b1, 1'b1, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 30);
        wait_out("s4_up", 0, 1'b1, 100, 2);
        apply(4'b0010, 1'b0, 1'b0, 2'd0, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 31);
        pos_sw = 4'b0000;
        light = 2'd0;
        wait_out("s4_stop", 0, 1'b0, 100, LIGHT_REACT_TICKS);
        wait_out("s4_down", 1, 1'b1, 100, 2);

        // Reset pulse while lowering.
        reset = 1'b1;
        @(negedge clk);
        chk("s6_motor_down", 16'(motor_down), 16'd0);
        chk("s6_motor_up", 16'(motor_up), 16'd0);
        chk("s6_tick", 16'(tick), 16'd0);
        chk("s6_fault", 16'(fault), 16'd0);
        chk("s6_cur_pos", 16'(cur_pos), 16'd0);
        reset = 1'b0;
        // Counter is 0 in this cycle, so the tick lands 15 cycles later (16th cycle).
        n = 0;
        while ((tick == 1'b0) && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        chk("s6_tick_restart", 16'(n), 16'd15);
        chk("s6_idle_motor_down", 16'(motor_down), 16'd0);

        // Top switch already active at reset exit; the 3-stop unit gets a manual target at stop 1.
        pos_sw = 4'b1000;
        pos_sw3 = 3'b010;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmd_valid3 = 1'b1; cmd_auto3 = 1'b0; cmd_target3 = 2'd1;
        apply(4'b1000, 1'b1, 1'b0, 2'd3, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 40);
        cmd_valid3 = 1'b0;
        apply(4'b1000, 1'b0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 41);
        chk("n3_at_stop1", 16'(at_target3), 16'd1);

        // NUM_POS=3: light 1 maps to stop 0, so it must lower from stop 1.
        cmd_valid3 = 1'b1; cmd_auto3 = 1'b1; light3 = 2'd1;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        wait_out("n3_down", 4, 1'b1, 80, -1);
        pos_sw3 = 3'b001;
        @(negedge clk);
        wait_out("n3_settle0", 5, 1'b1, 60, 2);
        chk("n3_cur_pos0", 16'(cur_pos3), 16'd0);

        // Out-of-range manual target clamps to the top stop.
        cmd_valid3 = 1'b1; cmd_auto3 = 1'b0; cmd_target3 = 2'd3;
        @(negedge clk);
        cmd_valid3 = 1'b0;
        chk("n3_clamp_up", 16'(motor_up3), 16'd1);
        pos_sw3 = 3'b100;
        @(negedge clk);
        wait_out("n3_settle_top", 5, 1'b1, 60, 2);
        chk("n3_cur_pos_top", 16'(cur_pos3), 16'd2);
        chk("n3_fault", 16'(fault3), 16'd0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
